// File: rtl/vote_counter_if.sv
// Signal bundle between the upstream voter/controller and vote_counter.
// No valid/ready here: vote_in, en and clr are level inputs sampled on every rising clk edge; outputs are registered.
interface vote_counter_if #(
    parameter int WIDTH = 4
);
    logic             vote_in;
    logic             en;
    logic             clr;
    logic             level;
    logic             pulse;
    logic             tc;
    logic [WIDTH-1:0] count;
    logic [1:0]       fsm_state;

    modport master (
        output vote_in, en, clr,
        input  level, pulse, tc, count, fsm_state
    );

    modport slave (
        input  vote_in, en, clr,
        output level, pulse, tc, count, fsm_state
    );
endinterface

// File: rtl/vote_counter.sv
// Debounces a voted level, strobes on each confirmed rise and counts rises modulo MODULUS.
// The filter state is exported on bus.fsm_state for observation.
module vote_counter #(
    parameter int STABLE  = 3,
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    vote_counter_if.slave bus
);
    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    // run counts consecutive new-value samples; reaching RUN_LAST on the next sample confirms
    localparam logic [3:0]       RUN_LAST  = 4'(STABLE - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULUS - 1);

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic             rise;
    logic             level_q, pulse_q, tc_q;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        rise    = 1'b0;
        case (state_q)
            LOW: begin
                if (bus.vote_in) begin
                    if (STABLE == 1) begin
                        state_d = HIGH;
                        rise    = 1'b1;
                    end else begin
                        state_d = RISE_CHK;
                        run_d   = 4'd1;
                    end
                end
            end
            RISE_CHK: begin
                if (bus.vote_in) begin
                    if (run_q == RUN_LAST) begin
                        state_d = HIGH;
                        run_d   = 4'd0;
                        rise    = 1'b1;
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end else begin
                    state_d = LOW;
                    run_d   = 4'd0;
                end
            end
            HIGH: begin
                if (!bus.vote_in) begin
                    if (STABLE == 1) begin
                        state_d = LOW;
                    end else begin
                        state_d = FALL_CHK;
                        run_d   = 4'd1;
                    end
                end
            end
            FALL_CHK: begin
                if (!bus.vote_in) begin
                    if (run_q == RUN_LAST) begin
                        state_d = LOW;
                        run_d   = 4'd0;
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end else begin
                    state_d = HIGH;
                    run_d   = 4'd0;
                end
            end
            default: begin
                state_d = LOW;
                run_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOW;
            run_q   <= 4'd0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            level_q <= (state_d == HIGH) || (state_d == FALL_CHK);
            pulse_q <= rise;
            // clr wins over a coincident increment; the pulse itself is unaffected
            if (bus.clr) begin
                count_q <= '0;
                tc_q    <= 1'b0;
            end else if (rise && bus.en) begin
                if (count_q == COUNT_MAX) begin
                    count_q <= '0;
                    tc_q    <= 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                    tc_q    <= 1'b0;
                end
            end else begin
                tc_q <= 1'b0;
            end
        end
    end

    assign bus.level     = level_q;
    assign bus.pulse     = pulse_q;
    assign bus.count     = count_q;
    assign bus.tc        = tc_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_vote_counter.sv
// Bench for vote_counter: directed scenarios followed by random traffic, all
// outputs compared every cycle against a streak-counting reference model.
module tb_vote_counter;
  localparam int STABLE  = 3;
  localparam int MODULUS = 10;
  localparam int WIDTH   = 4;
  localparam int W       = WIDTH + 3;

  logic clk;
  logic reset;

  vote_counter_if #(.WIDTH(WIDTH)) bus ();

  vote_counter #(
    .STABLE (STABLE),
    .MODULUS(MODULUS),
    .WIDTH  (WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: level flips once the input has disagreed with it for STABLE samples
  int m_level;
  int m_streak;
  int m_count;
  int m_pulse;
  int m_tc;

  logic [W-1:0] exp_q[$];
  int vectors;
  int miscompares;
  int pulses_seen;

  task automatic model_edge(input logic v, input logic e, input logic c, input logic r);
    int rise_now;
    if (r) begin
      m_level = 0; m_streak = 0; m_count = 0; m_pulse = 0; m_tc = 0;
    end else begin
      rise_now = 0;
      if (int'(v) != m_level) begin
        m_streak = m_streak + 1;
        if (m_streak == STABLE) begin
          m_level  = int'(v);
          m_streak = 0;
          rise_now = int'(v);
        end
      end else begin
        m_streak = 0;
      end
      m_pulse = rise_now;
      if (c) begin
        m_count = 0;
        m_tc    = 0;
      end else if (rise_now == 1 && e) begin
        m_tc    = (m_count == MODULUS - 1) ? 1 : 0;
        m_count = (m_count + 1) % MODULUS;
      end else begin
        m_tc = 0;
      end
    end
  endtask

  // driver: apply one input vector for one clock edge, then score all outputs
  task automatic step(input logic v, input logic e, input logic c, input logic r);
    logic [W-1:0] exp;
    @(negedge clk);
    bus.vote_in = v;
    bus.en      = e;
    bus.clr     = c;
    reset       = r;
    @(posedge clk);
    model_edge(v, e, c, r);
    exp_q.push_back({m_level[0], m_pulse[0], m_tc[0], m_count[WIDTH-1:0]});
    #1;
    exp = exp_q.pop_front();
    vectors++;
    if (bus.pulse === 1'b1) pulses_seen++;
    assert (bus.level === exp[W-1]) else begin
      miscompares++;
      $error("FAIL level @%0d: got %b want %b", vectors, bus.level, exp[W-1]);
    end
    assert (bus.pulse === exp[W-2]) else begin
      miscompares++;
      $error("FAIL pulse @%0d: got %b want %b", vectors, bus.pulse, exp[W-2]);
    end
    assert (bus.tc === exp[W-3]) else begin
      miscompares++;
      $error("FAIL tc @%0d: got %b want %b", vectors, bus.tc, exp[W-3]);
    end
    assert (bus.count === exp[WIDTH-1:0]) else begin
      miscompares++;
      $error("FAIL count @%0d: got %0d want %0d", vectors, bus.count, exp[WIDTH-1:0]);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic rise_fall(input logic e);
    for (int i = 0; i < STABLE; i++) step(1'b1, e, 1'b0, 1'b0);
    for (int i = 0; i < STABLE; i++) step(1'b0, e, 1'b0, 1'b0);
  endtask

  initial begin
    int len;
    logic v, e, c, r;
    vectors = 0; miscompares = 0; pulses_seen = 0;
    m_level = 0; m_streak = 0; m_count = 0; m_pulse = 0; m_tc = 0;
    reset = 1'b1; bus.vote_in = 1'b0; bus.en = 1'b0; bus.clr = 1'b0;

    // reset state, with vote_in high to show reset overrides it
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("reset_level", {7'd0, bus.level}, 8'd0);
    check("reset_count", {4'd0, bus.count}, 8'd0);

    // clean rise
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s1_level_early", {7'd0, bus.level}, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s1_level", {7'd0, bus.level}, 8'd1);
    check("s1_pulse", {7'd0, bus.pulse}, 8'd1);
    check("s1_count", {4'd0, bus.count}, 8'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s1_pulse_off", {7'd0, bus.pulse}, 8'd0);

    // glitches: short high burst while low, short dip while high
    for (int i = 0; i < STABLE; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < STABLE; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("s2_glitch_level", {7'd0, bus.level}, 8'd0);
    check("s2_glitch_count", {4'd0, bus.count}, 8'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("s2_dip_level", {7'd0, bus.level}, 8'd1);
    for (int i = 0; i < STABLE; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s2_dip_count", {4'd0, bus.count}, 8'd2);

    // wrap through MODULUS rises
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < STABLE; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MODULUS - 1; i++) rise_fall(1'b1);
    check("s3_count_max", {4'd0, bus.count}, 8'(MODULUS - 1));
    for (int i = 0; i < STABLE; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s3_wrap_count", {4'd0, bus.count}, 8'd0);
    check("s3_wrap_tc", {7'd0, bus.tc}, 8'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s3_tc_off", {7'd0, bus.tc}, 8'd0);

    // clr colliding with a confirmed rise at count = MODULUS-1
    for (int i = 0; i < STABLE; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < MODULUS - 1; i++) rise_fall(1'b1);
    check("s4_count_pre", {4'd0, bus.count}, 8'(MODULUS - 1));
    for (int i = 0; i < STABLE - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("s4_count", {4'd0, bus.count}, 8'd0);
    check("s4_tc", {7'd0, bus.tc}, 8'd0);
    check("s4_pulse", {7'd0, bus.pulse}, 8'd1);

    // enable gating
    for (int i = 0; i < STABLE; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    rise_fall(1'b1);
    pulses_seen = 0;
    for (int i = 0; i < 3; i++) rise_fall(1'b0);
    check("s5_pulses", 8'(pulses_seen), 8'd3);
    check("s5_count", {4'd0, bus.count}, 8'd1);

    // reset in the middle of a rise check
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s6_level_early", {7'd0, bus.level}, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("s6_level", {7'd0, bus.level}, 8'd1);
    check("s6_count", {4'd0, bus.count}, 8'd1);

    // random traffic: bursts of a held vote value, occasional clr/reset, mostly enabled
    for (int b = 0; b < 150; b++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        e = ($urandom_range(0, 7) != 0);
        c = ($urandom_range(0, 31) == 0);
        r = ($urandom_range(0, 99) == 0);
        step(v, e, c, r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // watchdog so the run cannot hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vote_counter.md
VOTE_COUNTER -- requirements
Module: vote_counter

Interface
REQ-001 Parameter STABLE, default 3: consecutive clock edges vote_in must hold a new value before the filtered level changes; legal range 1..15.
REQ-002 Parameter MODULUS, default 10: count wraps after MODULUS-1; legal range 2..2^WIDTH.
REQ-003 Parameter WIDTH, default 4: width of count.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port vote_in, input, 1: majority-vote result from the upstream 2-of-3 voter, same clock domain.
REQ-007 Port en, input, 1: count enable; when 0, confirmed rises still pulse but do not increment.
REQ-008 Port clr, input, 1: synchronous clear of count only; the filter state is unaffected.
REQ-009 Port level, output, 1: debounced (filtered) vote level.
REQ-010 Port pulse, output, 1: one-cycle strobe on each confirmed rise.
REQ-011 Port count, output, WIDTH: event counter, value range 0..MODULUS-1.
REQ-012 Port tc, output, 1: one-cycle terminal-count strobe on each wrap from MODULUS-1 to 0.

Function
REQ-013 The filter FSM SHALL have four states:
- LOW
- RISE_CHK
- HIGH
- FALL_CHK
REQ-014 Filter state transitions and actions SHALL be:
- LOW: vote_in=1 -> RISE_CHK, run=1; vote_in=0 -> stay LOW.
- RISE_CHK: vote_in=1 -> run+1; vote_in=0 -> back to LOW, run=0.
- HIGH, FALL_CHK: symmetric to LOW, RISE_CHK with vote_in inverted.
REQ-015 At the edge sampling the STABLE-th consecutive new value, the FSM SHALL enter HIGH or LOW, update level, and reset run to 0. With STABLE=1 the change is immediate from LOW/HIGH.
REQ-016 The latency from the first edge sampling vote_in=1 to level=1 SHALL be STABLE-1 further edges, with level updated as a register output after that edge.
REQ-017 A glitch shorter than STABLE edges SHALL produce no change on level, pulse, count or tc.
REQ-018 pulse SHALL be 1 for exactly the one cycle following the transition into HIGH and 0 otherwise; a transition into LOW produces no strobe.
REQ-019 At the edge that sets pulse: if en=1 and clr=0, count SHALL increment by 1, wrapping MODULUS-1 -> 0.
REQ-020 On that wrap, tc SHALL be 1 for that one cycle; tc is 0 at all other times.
REQ-021 clr=1 SHALL force count=0 and tc=0 at that edge and take priority over a simultaneous increment; the pulse from that event is still issued.
REQ-022 en=0 SHALL hold count and suppress tc.
REQ-023 The count arithmetic SHALL be modulo MODULUS with no value >= MODULUS ever visible. When MODULUS=2^WIDTH, the natural overflow is the wrap.
REQ-024 en and clr SHALL be sampled every edge, independent of the filter state.

Reset
REQ-025 reset=1 at a rising edge SHALL set state=LOW, run=0, level=0, pulse=0, count=0, tc=0, overriding all other inputs.
REQ-026 reset asserted mid-check (RISE_CHK/FALL_CHK) SHALL discard the partial run. After release, a vote_in already at 1 requires a full STABLE edges before level=1.
REQ-027 If vote_in is held at 1 through reset release, the first post-reset confirmed rise SHALL pulse and count normally.

Verification (STABLE=3, MODULUS=10, WIDTH=4)
REQ-028 Scenario 1 (clean rise): reset, en=1, vote_in 0->1 held -> level=1 and pulse=1 one cycle after the 3rd sampling edge; count=1; pulse 0 the next cycle.
REQ-029 Scenario 2 (glitch): vote_in high for 2 edges then low -> level, pulse, count unchanged. Repeat with a 1-edge low dip inside a high period -> level stays 1.
REQ-030 Scenario 3 (wrap): 10 clean pulses with en=1 -> count 0..9 then 0; tc=1 only in the cycle count returns to 0.
REQ-031 Scenario 4 (clr collision): count=9, clr=1 on the same edge as a confirmed rise -> count=0, tc=0, pulse=1.
REQ-032 Scenario 5 (enable gating): en=0 during 3 confirmed rises -> 3 pulses, count held at its prior value, tc=0.
REQ-033 Scenario 6 (reset mid-check): vote_in=1 for 2 edges, reset 1 edge, vote_in still 1 -> level rises only after 3 post-reset edges; count=1.
